piano_key_debounce: RTL

- Upstream stage of the LCD face-animation driver; produces its `pressed` input, plus note information for the audio path.
- Synchronises and debounces NKEYS raw active-low piano key inputs, then selects one active key by priority.
- Stretches `pressed` by a minimum hold time. The LCD frame loop samples `pressed` only once per image redraw, so short taps still show the "singing" image.

---
 rtl/piano_key_debounce.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/piano_key_debounce.sv
// Piano key front end: sync, debounce, priority select, hold-stretched pressed.
// Ports: LCD_CLK, RESETN; KEY_N raw keys (active-low); pressed, KEY_IDX, KEY_VALID, NOTE_ON.
module piano_key_debounce #(
  parameter int NKEYS           = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int HOLD_CYCLES     = 64
) (
  input  logic                     LCD_CLK,
  input  logic                     RESETN,
  input  logic [NKEYS-1:0]         KEY_N,
  output logic                     pressed,
  output logic [$clog2(NKEYS)-1:0] KEY_IDX,
  output logic                     KEY_VALID,
  output logic                     NOTE_ON
);

  localparam int IW = $clog2(NKEYS);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  // Flops hold raw KEY_N levels, so reset value 1 means released.
  logic [NKEYS-1:0] s1, s2;
  logic [NKEYS-1:0] sync;
  logic [NKEYS-1:0] db;
  logic [CW-1:0]    cnt [NKEYS];

  always_ff @(posedge LCD_CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= KEY_N;
      s2 <= s1;
    end
  end

  assign sync = ~s2;

  always_ff @(posedge LCD_CLK or negedge RESETN) begin
    if (!RESETN) begin
      db <= '0;
      for (int i = 0; i < NKEYS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NKEYS; i++) begin
        if (sync[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          db[i]  <= sync[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  logic          any;
  logic [IW-1:0] sel;

  assign any = |db;

  // Descending scan so the lowest set index wins.
  always_comb begin
    sel = '0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (db[i]) sel = IW'(i);
    end
  end

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          pressed_d, valid_d, note_d;
  logic [IW-1:0] idx_d;

  always_ff @(posedge LCD_CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q   <= IDLE;
      hold_q    <= '0;
      pressed   <= 1'b0;
      KEY_VALID <= 1'b0;
      KEY_IDX   <= '0;
      NOTE_ON   <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pressed   <= pressed_d;
      KEY_VALID <= valid_d;
      KEY_IDX   <= idx_d;
      NOTE_ON   <= note_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    pressed_d = pressed;
    valid_d   = KEY_VALID;
    idx_d     = KEY_IDX;
    note_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (any) begin
          state_d   = ACTIVE;
          pressed_d = 1'b1;
          valid_d   = 1'b1;
          idx_d     = sel;
          note_d    = 1'b1;
        end
      end
      ACTIVE: begin
        if (!any) begin
          state_d = HOLD;
          valid_d = 1'b0;
          hold_d  = HW'(HOLD_CYCLES - 1);
        end else if (sel != KEY_IDX) begin
          idx_d  = sel;
          note_d = 1'b1;
        end
      end
      HOLD: begin
        // A re-press is always a new note, even on the same key.
        if (any) begin
          state_d = ACTIVE;
          valid_d = 1'b1;
          idx_d   = sel;
          note_d  = 1'b1;
        end else if (hold_q == '0) begin
          state_d   = IDLE;
          pressed_d = 1'b0;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        hold_d    = '0;
        pressed_d = 1'b0;
        valid_d   = 1'b0;
        idx_d     = '0;
      end
    endcase
  end

endmodule
